// File: rtl/fp_pkg.sv
// Shared floating-point definitions for the iterative divider and the
// rounding helper (also used by the square-root datapath).
//   state_t  : divider FSM states
//   fclass_t : operand classification
//   FLAG_*   : bit positions inside the 5-bit {nv, dz, of, uf, nx} flag vector
//   bias()   : exponent bias for a given exponent width
//   qnan()   : canonical quiet NaN pattern, returned right-aligned in a wide
//              vector so that any format up to binary128 can slice it
package fp_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DIVIDE,
        ROUND,
        DONE
    } state_t;

    typedef enum logic [1:0] {
        ZERO,
        NORM,
        INF,
        NAN
    } fclass_t;

    localparam int FLAG_W  = 5;
    localparam int FLAG_NV = 4;
    localparam int FLAG_DZ = 3;
    localparam int FLAG_OF = 2;
    localparam int FLAG_UF = 1;
    localparam int FLAG_NX = 0;

    localparam int QNAN_MAX_W = 128;

    function automatic int bias(input int exp_w);
        return (1 << (exp_w - 1)) - 1;
    endfunction

    // {sign=0, exponent all ones, mantissa MSB set}
    function automatic logic [QNAN_MAX_W-1:0] qnan(input int exp_w, input int man_w);
        logic [QNAN_MAX_W-1:0] r;
        r = '0;
        for (int i = 0; i < exp_w; i++) begin
            r[man_w + i] = 1'b1;
        end
        r[man_w - 1] = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/fp_round_rne.sv
// Round-to-nearest-even plus range check for a normalised mantissa.
// Purely combinational so it can sit behind any iterative datapath.
// Ports:
//   mant    in  MAN_W+1  normalised mantissa including the hidden 1
//   guard   in  1        first bit below the mantissa LSB
//   sticky  in  1        OR of every bit below the guard bit
//   exp_in  in  EXP_W+2  biased exponent, two's complement (may be <= 0)
//   man_out out MAN_W    stored mantissa after rounding (0 on of/uf)
//   exp_out out EXP_W    stored exponent (all ones on of, 0 on uf)
//   of/uf/nx out 1       overflow, underflow (flush to zero), inexact
module fp_round_rne
    import fp_pkg::*;
#(
    parameter int EXP_W = 11,
    parameter int MAN_W = 52
) (
    input  logic [MAN_W:0]   mant,
    input  logic             guard,
    input  logic             sticky,
    input  logic [EXP_W+1:0] exp_in,
    output logic [MAN_W-1:0] man_out,
    output logic [EXP_W-1:0] exp_out,
    output logic             of,
    output logic             uf,
    output logic             nx
);

    localparam int EW2 = EXP_W + 2;
    localparam logic [EW2-1:0] E_MAX = EW2'((1 << EXP_W) - 1);

    logic             inc;
    logic [MAN_W+1:0] sum;
    logic [MAN_W-1:0] man_r;
    logic [EW2-1:0]   e_r;
    logic             e_neg;

    always_comb begin
        inc = guard & (sticky | mant[0]);
        sum = {1'b0, mant} + {{(MAN_W + 1){1'b0}}, inc};
        // A carry out of the hidden bit means the mantissa became 10.000...;
        // renormalise by one place, which leaves the stored bits all zero.
        if (sum[MAN_W+1]) begin
            man_r = sum[MAN_W:1];
            e_r   = exp_in + 1'b1;
        end else begin
            man_r = sum[MAN_W-1:0];
            e_r   = exp_in;
        end
        e_neg = e_r[EW2-1];
    end

    always_comb begin
        man_out = '0;
        exp_out = '0;
        of      = 1'b0;
        uf      = 1'b0;
        nx      = 1'b0;
        if (!e_neg && (e_r >= E_MAX)) begin
            exp_out = '1;
            of      = 1'b1;
            nx      = 1'b1;
        end else if (e_neg || (e_r == '0)) begin
            // Subnormal results are flushed to zero.
            uf = 1'b1;
            nx = 1'b1;
        end else begin
            man_out = man_r;
            exp_out = e_r[EXP_W-1:0];
            nx      = guard | sticky;
        end
    end

endmodule

// File: rtl/fp_div_iter.sv
// Multi-cycle IEEE-754 divider, result = a / b, radix-2 restoring division
// producing one quotient bit per cycle, round-to-nearest-even, subnormals
// flushed to zero.
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   in_valid/in_ready   operand handshake; a and b are captured on the edge
//                       where both are high. in_ready is high only in IDLE.
//   a, b                dividend / divisor, W = 1+EXP_W+MAN_W bits
//   out_valid/out_ready result handshake; out_valid stays high with result
//                       and flags stable until the edge where out_ready is
//                       high, then the FSM returns to IDLE (no new accept on
//                       that same edge).
//   result, flags       quotient and {nv, dz, of, uf, nx}
//   busy                FSM is not in IDLE
// Handshake rule: a transfer happens on a rising edge where valid and ready
// are both high; valid never depends on ready and, once raised, is held with
// its payload until the transfer edge.
module fp_div_iter
    import fp_pkg::*;
#(
    parameter int EXP_W = 11,
    parameter int MAN_W = 52
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W+MAN_W:0]   a,
    input  logic [EXP_W+MAN_W:0]   b,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   result,
    output logic [FLAG_W-1:0]      flags,
    output logic                   busy
);

    localparam int W     = 1 + EXP_W + MAN_W;
    localparam int NIT   = MAN_W + 3;
    localparam int EW2   = EXP_W + 2;
    localparam int RW    = MAN_W + 2;
    localparam int CNT_W = $clog2(NIT + 1);

    localparam logic [EW2-1:0]        BIAS_E    = EW2'(bias(EXP_W));
    localparam logic [QNAN_MAX_W-1:0] QNAN_FULL = qnan(EXP_W, MAN_W);
    localparam logic [W-1:0]          QNAN      = QNAN_FULL[W-1:0];
    localparam logic [CNT_W-1:0]      CNT_INIT  = CNT_W'(NIT - 1);
    localparam logic [EXP_W-1:0]      EXP_ONES  = '1;

    // ---------------------------------------------------------------
    // Operand fields and classification (used only on the accept edge)
    // ---------------------------------------------------------------
    logic             sa, sb, sign_in;
    logic [EXP_W-1:0] ea, eb;
    logic [MAN_W-1:0] ma, mb;
    fclass_t          ca, cb;

    assign sa      = a[W-1];
    assign sb      = b[W-1];
    assign ea      = a[W-2:MAN_W];
    assign eb      = b[W-2:MAN_W];
    assign ma      = a[MAN_W-1:0];
    assign mb      = b[MAN_W-1:0];
    assign sign_in = sa ^ sb;

    function automatic fclass_t classify(input logic [EXP_W-1:0] e, input logic [MAN_W-1:0] m);
        if (e == '0) begin
            return ZERO;
        end else if (e == EXP_ONES) begin
            return (m == '0) ? INF : NAN;
        end
        return NORM;
    endfunction

    assign ca = classify(ea, ma);
    assign cb = classify(eb, mb);

    // Special-case mux: anything that is not normal/normal finishes in one cycle.
    logic              special;
    logic [W-1:0]      spec_res;
    logic [FLAG_W-1:0] spec_flags;

    always_comb begin
        special    = 1'b1;
        spec_res   = '0;
        spec_flags = '0;
        if ((ca == NAN) || (cb == NAN) || ((ca == ZERO) && (cb == ZERO)) ||
            ((ca == INF) && (cb == INF))) begin
            spec_res            = QNAN;
            spec_flags[FLAG_NV] = 1'b1;
        end else if (ca == INF) begin
            spec_res = {sign_in, EXP_ONES, {MAN_W{1'b0}}};
        end else if (cb == ZERO) begin
            // Dividend is a non-zero finite here.
            spec_res            = {sign_in, EXP_ONES, {MAN_W{1'b0}}};
            spec_flags[FLAG_DZ] = 1'b1;
        end else if ((ca == ZERO) || (cb == INF)) begin
            spec_res = {sign_in, {(W - 1){1'b0}}};
        end else begin
            special = 1'b0;
        end
    end

    // ---------------------------------------------------------------
    // FSM
    // ---------------------------------------------------------------
    state_t            state, state_next;
    logic [CNT_W-1:0]  cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid) state_next = special ? DONE : DIVIDE;
            DIVIDE:  if (cnt_q == '0) state_next = ROUND;
            ROUND:   state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
        busy      = (state != IDLE);
    end

    // ---------------------------------------------------------------
    // Datapath registers
    // ---------------------------------------------------------------
    // rem_q holds the partial remainder; it always stays below 2*divisor,
    // so MAN_W+2 bits are enough. quo_q collects quotient bits MSB first,
    // the first one having weight 2^0.
    logic [RW-1:0]     rem_q;
    logic [MAN_W:0]    dvsr_q;
    logic [NIT-1:0]    quo_q;
    logic [EW2-1:0]    exp_q;
    logic              sign_q;
    logic [W-1:0]      result_q;
    logic [FLAG_W-1:0] flags_q;

    logic              q_bit;
    logic [RW-1:0]     rem_sel;

    always_comb begin
        q_bit   = (rem_q >= {1'b0, dvsr_q});
        rem_sel = q_bit ? (rem_q - {1'b0, dvsr_q}) : rem_q;
    end

    // Normalisation: q lies in (0.5, 2), so at most one left shift is needed.
    logic [MAN_W:0]    norm_mant;
    logic              norm_g, norm_s;
    logic [EW2-1:0]    norm_exp;

    always_comb begin
        if (quo_q[NIT-1]) begin
            norm_mant = quo_q[NIT-1:2];
            norm_g    = quo_q[1];
            norm_s    = quo_q[0] | (|rem_q);
            norm_exp  = exp_q;
        end else begin
            norm_mant = quo_q[NIT-2:1];
            norm_g    = quo_q[0];
            norm_s    = |rem_q;
            norm_exp  = exp_q - 1'b1;
        end
    end

    logic [MAN_W-1:0]  rnd_man;
    logic [EXP_W-1:0]  rnd_exp;
    logic              rnd_of, rnd_uf, rnd_nx;
    logic [FLAG_W-1:0] rnd_flags;

    fp_round_rne #(
        .EXP_W (EXP_W),
        .MAN_W (MAN_W)
    ) u_round (
        .mant    (norm_mant),
        .guard   (norm_g),
        .sticky  (norm_s),
        .exp_in  (norm_exp),
        .man_out (rnd_man),
        .exp_out (rnd_exp),
        .of      (rnd_of),
        .uf      (rnd_uf),
        .nx      (rnd_nx)
    );

    always_comb begin
        rnd_flags          = '0;
        rnd_flags[FLAG_OF] = rnd_of;
        rnd_flags[FLAG_UF] = rnd_uf;
        rnd_flags[FLAG_NX] = rnd_nx;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rem_q    <= '0;
            dvsr_q   <= '0;
            quo_q    <= '0;
            exp_q    <= '0;
            sign_q   <= 1'b0;
            cnt_q    <= '0;
            result_q <= '0;
            flags_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sign_q <= sign_in;
                        if (special) begin
                            result_q <= spec_res;
                            flags_q  <= spec_flags;
                        end else begin
                            rem_q  <= {1'b0, 1'b1, ma};
                            dvsr_q <= {1'b1, mb};
                            quo_q  <= '0;
                            cnt_q  <= CNT_INIT;
                            exp_q  <= {2'b00, ea} - {2'b00, eb} + BIAS_E;
                        end
                    end
                end
                DIVIDE: begin
                    rem_q <= rem_sel << 1;
                    quo_q <= {quo_q[NIT-2:0], q_bit};
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                ROUND: begin
                    result_q <= {sign_q, rnd_exp, rnd_man};
                    flags_q  <= rnd_flags;
                end
                default: begin
                end
            endcase
        end
    end

    assign result = result_q;
    assign flags  = flags_q;

endmodule

// File: tb/tb_fp_div_iter.sv
// Bench for fp_div_iter: a binary64 and a binary32 instance, directed
// vectors, backpressure, mid-operation reset and randomized operands
// checked against an integer-arithmetic reference model.
module tb_fp_div_iter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;

    logic        v64, ir64, ov64, or64, busy64;
    logic [63:0] a64, b64, res64;
    logic [4:0]  fl64;

    logic        v32, ir32, ov32, or32, busy32;
    logic [31:0] a32, b32, res32;
    logic [4:0]  fl32;

    fp_div_iter #(.EXP_W(11), .MAN_W(52)) dut64 (
        .clk(clk), .rst(rst), .in_valid(v64), .in_ready(ir64), .a(a64), .b(b64),
        .out_valid(ov64), .out_ready(or64), .result(res64), .flags(fl64), .busy(busy64)
    );

    fp_div_iter #(.EXP_W(8), .MAN_W(23)) dut32 (
        .clk(clk), .rst(rst), .in_valid(v32), .in_ready(ir32), .a(a32), .b(b32),
        .out_valid(ov32), .out_ready(or32), .result(res32), .flags(fl32), .busy(busy32)
    );

    int total  = 0;
    int passed = 0;
    logic [76:0] exp_q[$];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Checking and driver tasks
    // ------------------------------------------------------------------
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] expv);
        total++;
        assert (got === expv) begin
            passed++;
        end else begin
            $error("FAIL %s: observed %h expected %h", tag, got, expv);
        end
    endtask

    task automatic drive_in(input bit w32, input logic [63:0] a, input logic [63:0] b, input logic v);
        if (w32) begin
            a32 = a[31:0];
            b32 = b[31:0];
            v32 = v;
        end else begin
            a64 = a;
            b64 = b;
            v64 = v;
        end
    endtask

    function automatic logic get_ready(input bit w32);
        return w32 ? ir32 : ir64;
    endfunction

    function automatic logic get_valid(input bit w32);
        return w32 ? ov32 : ov64;
    endfunction

    function automatic logic [63:0] get_result(input bit w32);
        return w32 ? {32'd0, res32} : res64;
    endfunction

    function automatic logic [4:0] get_flags(input bit w32);
        return w32 ? fl32 : fl64;
    endfunction

    // Presents operands and returns right after the accepting clock edge.
    task automatic issue(input bit w32, input logic [63:0] a, input logic [63:0] b);
        int n;
        @(negedge clk);
        drive_in(w32, a, b, 1'b1);
        n = 0;
        while (!get_ready(w32) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("accept_wait", 64'(n < 200), 64'd1);
        @(posedge clk);
    endtask

    // Drops in_valid, scrambles the operand inputs and counts edges
    // (accept edge included) until out_valid is seen.
    task automatic collect(input bit w32, output logic [63:0] res, output logic [4:0] fl,
                           output int lat);
        @(negedge clk);
        drive_in(w32, {$urandom, $urandom}, {$urandom, $urandom}, 1'b0);
        lat = 1;
        while (!get_valid(w32) && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        res = get_result(w32);
        fl  = get_flags(w32);
    endtask

    task automatic op(input bit w32, input logic [63:0] a, input logic [63:0] b,
                      output logic [63:0] res, output logic [4:0] fl, output int lat);
        issue(w32, a, b);
        collect(w32, res, fl, lat);
    endtask

    // ------------------------------------------------------------------
    // Reference model: exact integer quotient, then RNE on the bits
    // ------------------------------------------------------------------
    function automatic void ref_div(input int ew, input int mw, input logic [63:0] a,
                                    input logic [63:0] b, output logic [63:0] res,
                                    output logic [4:0] fl, output bit special);
        int          emax, ea, eb, e, ca, cb;
        logic [63:0] mmask, ma, mb, inf_v, qnan_v, zero_v;
        logic        sa, sb, sg, g, s;
        logic [127:0] x, d, q, r, mant;

        emax   = (1 << ew) - 1;
        mmask  = (64'd1 << mw) - 1;
        sa     = a[ew + mw];
        sb     = b[ew + mw];
        ea     = int'((a >> mw) & 64'(emax));
        eb     = int'((b >> mw) & 64'(emax));
        ma     = a & mmask;
        mb     = b & mmask;
        sg     = sa ^ sb;
        inf_v  = (64'(sg) << (ew + mw)) | (64'(emax) << mw);
        zero_v = 64'(sg) << (ew + mw);
        qnan_v = (64'(emax) << mw) | (64'd1 << (mw - 1));
        // 0 zero, 1 normal, 2 inf, 3 nan
        ca = (ea == 0) ? 0 : ((ea == emax) ? ((ma == 0) ? 2 : 3) : 1);
        cb = (eb == 0) ? 0 : ((eb == emax) ? ((mb == 0) ? 2 : 3) : 1);

        special = 1'b1;
        fl      = 5'b00000;
        res     = '0;
        if (ca == 3 || cb == 3 || (ca == 0 && cb == 0) || (ca == 2 && cb == 2)) begin
            res = qnan_v;
            fl  = 5'b10000;
        end else if (ca == 2) begin
            res = inf_v;
        end else if (cb == 0) begin
            res = inf_v;
            fl  = 5'b01000;
        end else if (ca == 0 || cb == 2) begin
            res = zero_v;
        end else begin
            special = 1'b0;
            x = 128'((64'd1 << mw) | ma) << (mw + 2);
            d = 128'((64'd1 << mw) | mb);
            q = x / d;
            r = x % d;
            e = ea - eb + ((1 << (ew - 1)) - 1);
            if (q >= (128'd1 << (mw + 2))) begin
                mant = q >> 2;
                g    = q[1];
                s    = q[0] | (r != 0);
            end else begin
                mant = q >> 1;
                g    = q[0];
                s    = (r != 0);
                e    = e - 1;
            end
            if (g && (s || mant[0])) mant = mant + 128'd1;
            if (mant == (128'd1 << (mw + 1))) begin
                mant = mant >> 1;
                e    = e + 1;
            end
            if (e >= emax) begin
                res = inf_v;
                fl  = 5'b00101;
            end else if (e <= 0) begin
                res = zero_v;
                fl  = 5'b00011;
            end else begin
                res = (64'(sg) << (ew + mw)) | (64'(e) << mw) | (mant[63:0] & mmask);
                fl  = {4'b0000, g | s};
            end
        end
    endfunction

    function automatic logic [63:0] gen_operand(input int ew, input int mw);
        int          sel, e, emax, bs;
        logic [63:0] man, mmask;
        logic        s;
        emax  = (1 << ew) - 1;
        bs    = (1 << (ew - 1)) - 1;
        mmask = (64'd1 << mw) - 1;
        sel   = int'($urandom_range(0, 15));
        s     = 1'($urandom_range(0, 1));
        man   = {$urandom, $urandom} & mmask;
        case (sel)
            0: e = 0;
            1: begin
                e = emax;
                if ($urandom_range(0, 1) == 1) man = '0;
            end
            2: e = int'($urandom_range(1, emax - 1));
            3: begin
                e   = bs + int'($urandom_range(0, 8)) - 4;
                man = mmask;
            end
            4: begin
                e   = bs;
                man = '0;
            end
            default: e = bs + int'($urandom_range(0, 40)) - 20;
        endcase
        return (64'(s) << (ew + mw)) | (64'(e) << mw) | man;
    endfunction

    typedef struct {
        bit          w32;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] res;
        logic [4:0]  fl;
        int          lat;
        string       tag;
    } vec_t;

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        vec_t        dir_v[9];
        logic [63:0] res, ra, rb, eres;
        logic [4:0]  fl, efl;
        logic [76:0] ent;
        int          lat, elat;
        bit          sp, seen;

        dir_v[0] = '{0, 64'h4018000000000000, 64'h4000000000000000, 64'h4008000000000000, 5'b00000, 57, "div_6_2"};
        dir_v[1] = '{0, 64'h3FF0000000000000, 64'h4008000000000000, 64'h3FD5555555555555, 5'b00001, 57, "div_1_3_d"};
        dir_v[2] = '{1, 64'h3F800000, 64'h40400000, 64'h3EAAAAAB, 5'b00001, 28, "div_1_3_s"};
        dir_v[3] = '{0, 64'h3FF0000000000000, 64'h0, 64'h7FF0000000000000, 5'b01000, 1, "div_1_0"};
        dir_v[4] = '{0, 64'h0, 64'h0, 64'h7FF8000000000000, 5'b10000, 1, "div_0_0"};
        dir_v[5] = '{0, 64'hBFF0000000000000, 64'h7FF0000000000000, 64'h8000000000000000, 5'b00000, 1, "div_m1_inf"};
        dir_v[6] = '{0, 64'h7FEFFFFFFFFFFFFF, 64'h3FE0000000000000, 64'h7FF0000000000000, 5'b00101, 57, "overflow"};
        dir_v[7] = '{0, 64'h0010000000000000, 64'h4000000000000000, 64'h0000000000000000, 5'b00011, 57, "underflow"};
        dir_v[8] = '{1, 64'h7FC00001, 64'h3F800000, 64'h7FC00000, 5'b10000, 1, "nan_in_s"};

        // Clock/reset
        rst  = 1'b1;
        v64  = 1'b0; a64 = '0; b64 = '0; or64 = 1'b1;
        v32  = 1'b0; a32 = '0; b32 = '0; or32 = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_in_ready", 64'(ir64), 64'd1);
        check("rst_out_valid", 64'(ov64), 64'd0);
        check("rst_busy", 64'(busy64), 64'd0);
        check("rst_result", res64, 64'd0);
        check("rst_flags", 64'(fl64), 64'd0);

        // Directed vectors
        foreach (dir_v[i]) begin
            op(dir_v[i].w32, dir_v[i].a, dir_v[i].b, res, fl, lat);
            check({dir_v[i].tag, "_res"}, res, dir_v[i].res);
            check({dir_v[i].tag, "_flags"}, 64'(fl), 64'(dir_v[i].fl));
            check({dir_v[i].tag, "_lat"}, 64'(lat), 64'(dir_v[i].lat));
        end

        // Backpressure, with a second op waiting on the input side
        or64 = 1'b0;
        op(0, 64'h4018000000000000, 64'h4000000000000000, res, fl, lat);
        check("bp_first_res", res, 64'h4008000000000000);
        check("bp_first_lat", 64'(lat), 64'd57);
        drive_in(0, 64'h3FF0000000000000, 64'h4008000000000000, 1'b1);
        repeat (10) begin
            @(negedge clk);
            check("bp_hold_res", res64, 64'h4008000000000000);
            check("bp_hold_flags", 64'(fl64), 64'd0);
            check("bp_hold_in_ready", 64'(ir64), 64'd0);
            check("bp_hold_valid", 64'(ov64), 64'd1);
        end
        or64 = 1'b1;
        @(negedge clk);
        check("bp_release_valid", 64'(ov64), 64'd0);
        check("bp_release_in_ready", 64'(ir64), 64'd1);
        @(posedge clk);
        collect(0, res, fl, lat);
        check("bp_second_res", res, 64'h3FD5555555555555);
        check("bp_second_flags", 64'(fl), 64'd1);
        check("bp_second_lat", 64'(lat), 64'd57);

        // Reset in the middle of a divide
        issue(0, 64'h4018000000000000, 64'h4000000000000000);
        @(negedge clk);
        v64 = 1'b0;
        repeat (19) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_in_ready", 64'(ir64), 64'd1);
        check("midrst_out_valid", 64'(ov64), 64'd0);
        check("midrst_busy", 64'(busy64), 64'd0);
        check("midrst_result", res64, 64'd0);
        check("midrst_flags", 64'(fl64), 64'd0);
        seen = 1'b0;
        repeat (70) begin
            @(negedge clk);
            if (ov64) seen = 1'b1;
        end
        check("midrst_no_output", 64'(seen), 64'd0);
        op(0, 64'h4018000000000000, 64'h4000000000000000, res, fl, lat);
        check("midrst_after_res", res, 64'h4008000000000000);
        check("midrst_after_flags", 64'(fl), 64'd0);
        check("midrst_after_lat", 64'(lat), 64'd57);

        // Randomized operands against the reference model
        for (int i = 0; i < 80; i++) begin
            bit w32;
            int ew, mw;
            w32 = (i % 2) == 1;
            ew  = w32 ? 8 : 11;
            mw  = w32 ? 23 : 52;
            ra  = gen_operand(ew, mw);
            rb  = gen_operand(ew, mw);
            ref_div(ew, mw, ra, rb, eres, efl, sp);
            elat = sp ? 1 : mw + 5;
            exp_q.push_back({8'(elat), efl, eres});
            op(w32, ra, rb, res, fl, lat);
            ent = exp_q.pop_front();
            check(w32 ? "rand32_res" : "rand64_res", res, ent[63:0]);
            check(w32 ? "rand32_flags" : "rand64_flags", 64'(fl), 64'(ent[68:64]));
            check(w32 ? "rand32_lat" : "rand64_lat", 64'(lat), 64'(ent[76:69]));
        end
        check("queue_empty", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
